// File: rtl/fwd_scoreboard_pkg.sv
// Shared constants for the forwarding scoreboard: select encoding and stage-entry field layout.
// Optional perf counters are enabled by defining FWD_PERF_EN.
package fwd_scoreboard_pkg;

  localparam int FWD_SEL_RF = 0;

  // Stage entry layout, LSB first: valid, writes-back, float RF, load, then rd index
  localparam int ENT_VLD = 0;
  localparam int ENT_WB  = 1;
  localparam int ENT_FP  = 2;
  localparam int ENT_LD  = 3;
  localparam int ENT_RD  = 4;

  function automatic int sel_w(input int num_stages);
    return $clog2(num_stages + 1);
  endfunction

  function automatic int ent_w(input int reg_aw);
    return ENT_RD + reg_aw;
  endfunction

endpackage

// File: rtl/fwd_scoreboard_match.sv
// Per-source comparator: finds the youngest in-flight producer of one ID operand
// and reports either its stage index or that its result is not yet available.
module fwd_scoreboard_match
  import fwd_scoreboard_pkg::*;
#(
  parameter int NUM_STAGES = 3,
  parameter int REG_AW     = 5,
  parameter int LOAD_LAT   = 2,
  parameter int SELW       = sel_w(NUM_STAGES)
) (
  input  logic [NUM_STAGES*(ENT_RD+REG_AW)-1:0] ent,
  input  logic [REG_AW-1:0]                     rs,
  input  logic                                  rs_fp,
  input  logic                                  rs_use,
  output logic [SELW-1:0]                       sel,
  output logic                                  not_ready
);

  localparam int EW = ent_w(REG_AW);

  logic [NUM_STAGES-1:0] hit;
  logic [NUM_STAGES-1:0] rdy;
  logic                  found;

  for (genvar g = 0; g < NUM_STAGES; g++) begin : g_stage
    logic [EW-1:0] e;
    assign e = ent[g*EW +: EW];
    // Integer x0 is hard-wired zero and never a forwarding source; float f0 is a real register
    assign hit[g] = e[ENT_VLD] && e[ENT_WB] && rs_use
                    && (e[ENT_RD +: REG_AW] == rs) && (e[ENT_FP] == rs_fp)
                    && !((e[ENT_RD +: REG_AW] == '0) && !e[ENT_FP]);
    assign rdy[g] = !e[ENT_LD] || ((g + 1) >= LOAD_LAT);
  end

  always_comb begin
    sel       = SELW'(FWD_SEL_RF);
    not_ready = 1'b0;
    found     = 1'b0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      if (!found && hit[k]) begin
        found = 1'b1;
        if (rdy[k]) sel = SELW'(k + 1);
        else        not_ready = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fwd_scoreboard.sv
// Forwarding + load-use hazard unit tracking in-flight writes over NUM_STAGES stages after ID.
// Define FWD_PERF_EN to add the perf_stall_cnt / perf_fwd_cnt counter ports.
module fwd_scoreboard
  import fwd_scoreboard_pkg::*;
#(
  parameter int NUM_SRC    = 3,
  parameter int NUM_STAGES = 3,
  parameter int REG_AW     = 5,
  parameter int LOAD_LAT   = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              id_valid,
  input  logic [NUM_SRC*REG_AW-1:0]         id_rs,
  input  logic [NUM_SRC-1:0]                id_rs_fp,
  input  logic [NUM_SRC-1:0]                id_rs_use,
  input  logic [REG_AW-1:0]                 id_rd,
  input  logic                              id_rd_fp,
  input  logic                              id_wb,
  input  logic                              id_is_load,
  input  logic                              ex_hold,
  input  logic                              flush,
  output logic [NUM_SRC*sel_w(NUM_STAGES)-1:0] fwd_sel,
  output logic                              stall_id
`ifdef FWD_PERF_EN
  ,
  output logic [31:0]                       perf_stall_cnt,
  output logic [31:0]                       perf_fwd_cnt
`endif
);

  localparam int SELW = sel_w(NUM_STAGES);
  localparam int EW   = ent_w(REG_AW);
  localparam int PW   = EW - 1;

  // Valid bits are control and reset; the payload is qualified by valid and never reset
  logic [NUM_STAGES-1:0]    stg_vld;
  logic [NUM_STAGES*PW-1:0] stg_pl;
  logic [NUM_STAGES*EW-1:0] ent_view;
  logic [PW-1:0]            id_pl;
  logic [NUM_SRC-1:0]       not_ready;
  logic                     adv_s1;

  assign id_pl = {id_rd, id_is_load, id_rd_fp, id_wb};

  for (genvar g = 0; g < NUM_STAGES; g++) begin : g_view
    assign ent_view[g*EW +: EW] = {stg_pl[g*PW +: PW], stg_vld[g]};
  end

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    fwd_scoreboard_match #(
      .NUM_STAGES (NUM_STAGES),
      .REG_AW     (REG_AW),
      .LOAD_LAT   (LOAD_LAT),
      .SELW       (SELW)
    ) u_match (
      .ent       (ent_view),
      .rs        (id_rs[i*REG_AW +: REG_AW]),
      .rs_fp     (id_rs_fp[i]),
      .rs_use    (id_rs_use[i]),
      .sel       (fwd_sel[i*SELW +: SELW]),
      .not_ready (not_ready[i])
    );
  end

  // A flush overrides any load-use stall: the stalled instruction is being killed anyway
  assign stall_id = id_valid && !flush && (|not_ready);
  assign adv_s1   = id_valid && !stall_id && !flush;

  // Stage boundary: ID -> stage 1 -> ... -> NUM_STAGES, frozen by ex_hold
  always_ff @(posedge clk) begin
    if (rst) begin
      stg_vld <= '0;
    end else if (!ex_hold) begin
      for (int k = NUM_STAGES - 1; k > 0; k--) stg_vld[k] <= stg_vld[k-1];
      stg_vld[0] <= adv_s1;
    end else if (flush) begin
      stg_vld[0] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!ex_hold) begin
      for (int k = NUM_STAGES - 1; k > 0; k--) stg_pl[k*PW +: PW] <= stg_pl[(k-1)*PW +: PW];
      stg_pl[0 +: PW] <= id_pl;
    end
  end

`ifdef FWD_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cnt <= '0;
      perf_fwd_cnt   <= '0;
    end else begin
      if (stall_id)                 perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (id_valid && (|fwd_sel))   perf_fwd_cnt   <= perf_fwd_cnt + 32'd1;
    end
  end
`else
  // Counters not built in this configuration
`endif

endmodule
